// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: owns both 5x5 boards, the cursor, button conditioning,
// the PC's LFSR cell picker and the turn FSM. Boards are read through a registered port.
module battleship_game_ctrl #(
  parameter int          GRID      = 5,
  parameter int          NBOAT_MAX = 8,
  parameter int          LOCKOUT   = 1000,
  parameter int          PC_DELAY  = 255,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_fire,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic [3:0] nboat,
  input  logic       rd_board,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell,
  output logic [2:0] cur_row,
  output logic [2:0] cur_col,
  output logic       cur_board,
  output logic [2:0] state_o,
  output logic [3:0] hits_pl,
  output logic [3:0] hits_pc,
  output logic       game_over,
  output logic       winner
);

  localparam logic [2:0] S_PLACE_PLAYER = 3'd0;
  localparam logic [2:0] S_PLACE_PC     = 3'd1;
  localparam logic [2:0] S_PLAYER_TURN  = 3'd2;
  localparam logic [2:0] S_PC_TURN      = 3'd3;
  localparam logic [2:0] S_GAME_OVER    = 3'd4;

  localparam int         LW     = (LOCKOUT  > 0) ? $clog2(LOCKOUT + 1)  : 1;
  localparam int         DW     = (PC_DELAY > 0) ? $clog2(PC_DELAY + 1) : 1;
  localparam logic [2:0] GMAX   = 3'(GRID - 1);
  localparam logic [3:0] NB_MAX = 4'(NBOAT_MAX);

  logic [2:0]    state;
  logic [1:0]    board_pl [GRID][GRID];
  logic [1:0]    board_en [GRID][GRID];
  logic [2:0]    fire_sync, right_sync, down_sync;
  logic [LW-1:0] lock_cnt;
  logic [DW-1:0] delay_cnt;
  logic [7:0]    lfsr;
  logic [3:0]    count, nb_q, nb;
  logic          nb_valid;
  logic          fire_rise, right_rise, down_rise, lock_zero;
  logic          fire_ev, right_ev, down_ev;
  logic [2:0]    rnd_row, rnd_col, next_row, next_col;
  logic          rnd_ok;
  logic [1:0]    rnd_pl, rnd_en, pl_cur, en_cur;

  function automatic logic [3:0] clamp_nb(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > NB_MAX) return NB_MAX;
    return n;
  endfunction

  assign fire_rise  = fire_sync[1]  & ~fire_sync[2];
  assign right_rise = right_sync[1] & ~right_sync[2];
  assign down_rise  = down_sync[1]  & ~down_sync[2];
  assign lock_zero  = (lock_cnt == '0);
  assign fire_ev    = fire_rise & lock_zero;
  assign right_ev   = right_rise & lock_zero & ~fire_rise;
  assign down_ev    = down_rise & lock_zero & ~fire_rise;

  // Boat count is live from nboat until first captured after reset.
  assign nb       = nb_valid ? nb_q : clamp_nb(nboat);
  assign rnd_row  = lfsr[2:0];
  assign rnd_col  = lfsr[5:3];
  assign next_row = (cur_row == GMAX) ? 3'd0 : cur_row + 3'd1;
  assign next_col = (cur_col == GMAX) ? 3'd0 : cur_col + 3'd1;
  assign pl_cur   = board_pl[cur_row][cur_col];
  assign en_cur   = board_en[cur_row][cur_col];

  assign state_o   = state;
  assign cur_board = (state != S_PLACE_PLAYER);
  assign game_over = (state == S_GAME_OVER);

  // Look up the LFSR-selected cell on both boards, guarding rows/cols past the grid.
  always_comb begin
    rnd_ok = (rnd_row <= GMAX) && (rnd_col <= GMAX);
    rnd_pl = 2'b00;
    rnd_en = 2'b00;
    if (rnd_ok) begin
      rnd_pl = board_pl[rnd_row][rnd_col];
      rnd_en = board_en[rnd_row][rnd_col];
    end
  end

  // Button synchronizers, lockout down-counter and free-running LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_sync  <= '0;
      right_sync <= '0;
      down_sync  <= '0;
      lock_cnt   <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      fire_sync  <= {fire_sync[1:0],  btn_fire};
      right_sync <= {right_sync[1:0], btn_right};
      down_sync  <= {down_sync[1:0],  btn_down};
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (lock_zero && (fire_rise || right_rise || down_rise))
        lock_cnt <= LW'(LOCKOUT);
      else if (!lock_zero)
        lock_cnt <= lock_cnt - LW'(1);
    end
  end

  // Registered board read port for the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_cell <= 2'b00;
    else if ((rd_row <= GMAX) && (rd_col <= GMAX))
      rd_cell <= rd_board ? board_en[rd_row][rd_col] : board_pl[rd_row][rd_col];
    else
      rd_cell <= 2'b00;
  end

  // Turn FSM: boards, cursor, counters and winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < GRID; r++)
        for (int c = 0; c < GRID; c++) begin
          board_pl[r][c] <= 2'b00;
          board_en[r][c] <= 2'b00;
        end
      state     <= S_PLACE_PLAYER;
      cur_row   <= 3'd0;
      cur_col   <= 3'd0;
      count     <= 4'd0;
      hits_pl   <= 4'd0;
      hits_pc   <= 4'd0;
      winner    <= 1'b0;
      delay_cnt <= '0;
      nb_q      <= 4'd0;
      nb_valid  <= 1'b0;
    end else begin
      if (!nb_valid) begin
        nb_valid <= 1'b1;
        nb_q     <= clamp_nb(nboat);
      end
      if (right_ev) cur_col <= next_col;
      if (down_ev)  cur_row <= next_row;
      case (state)
        S_PLACE_PLAYER: begin
          if (fire_ev && pl_cur == 2'b00) begin
            board_pl[cur_row][cur_col] <= 2'b01;
            if (count + 4'd1 == nb) begin
              count <= 4'd0;
              state <= S_PLACE_PC;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        S_PLACE_PC: begin
          if (rnd_ok && rnd_en == 2'b00) begin
            board_en[rnd_row][rnd_col] <= 2'b01;
            if (count + 4'd1 == nb) begin
              count   <= 4'd0;
              state   <= S_PLAYER_TURN;
              cur_row <= 3'd0;
              cur_col <= 3'd0;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        S_PLAYER_TURN: begin
          if (fire_ev && !en_cur[1]) begin
            board_en[cur_row][cur_col] <= {1'b1, en_cur[0]};
            delay_cnt <= DW'(PC_DELAY);
            state     <= S_PC_TURN;
            if (en_cur[0]) begin
              hits_pl <= hits_pl + 4'd1;
              if (hits_pl + 4'd1 == nb) begin
                winner <= 1'b0;
                state  <= S_GAME_OVER;
              end
            end
          end
        end
        S_PC_TURN: begin
          if (delay_cnt != '0) begin
            delay_cnt <= delay_cnt - DW'(1);
          end else if (rnd_ok && !rnd_pl[1]) begin
            board_pl[rnd_row][rnd_col] <= {1'b1, rnd_pl[0]};
            state <= S_PLAYER_TURN;
            if (rnd_pl[0]) begin
              hits_pc <= hits_pc + 4'd1;
              if (hits_pc + 4'd1 == nb) begin
                winner <= 1'b1;
                state  <= S_GAME_OVER;
              end
            end
          end
        end
        S_GAME_OVER: begin
          if (fire_ev) begin
            for (int r = 0; r < GRID; r++)
              for (int c = 0; c < GRID; c++) begin
                board_pl[r][c] <= 2'b00;
                board_en[r][c] <= 2'b00;
              end
            hits_pl <= 4'd0;
            hits_pc <= 4'd0;
            cur_row <= 3'd0;
            cur_col <= 3'd0;
            count   <= 4'd0;
            nb_q    <= clamp_nb(nboat);
            state   <= S_PLACE_PLAYER;
          end
        end
        default: state <= S_PLACE_PLAYER;
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl: placement table, lockout, turns, game over, reset.
module tb_battleship_game_ctrl;

  localparam int LOCKOUT  = 1000;
  localparam int PC_DELAY = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_fire = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
  logic [3:0] nboat = 4'd2;
  logic       rd_board = 1'b0;
  logic [2:0] rd_row = 3'd0, rd_col = 3'd0;
  logic [1:0] rd_cell;
  logic [2:0] cur_row, cur_col, state_o;
  logic       cur_board, game_over, winner;
  logic [3:0] hits_pl, hits_pc;

  battleship_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .btn_fire(btn_fire), .btn_right(btn_right),
    .btn_down(btn_down), .nboat(nboat), .rd_board(rd_board), .rd_row(rd_row),
    .rd_col(rd_col), .rd_cell(rd_cell), .cur_row(cur_row), .cur_col(cur_col),
    .cur_board(cur_board), .state_o(state_o), .hits_pl(hits_pl), .hits_pc(hits_pc),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int act;     // 0 fire, 1 right, 2 down
    int e_state;
    int e_row;
    int e_col;
    int c_row;
    int c_col;
    int e_cell;
  } vec_t;

  vec_t       vecs [10];
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_row = 0, exp_col = 0;
  logic [1:0] scan_buf [25];
  logic [1:0] pl_model [25];
  int         boat_r [2];
  int         boat_c [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 fire, 1 right, 2 down, 3 fire+right together
  task automatic press(input int which);
    @(negedge clk);
    btn_fire  = (which == 0 || which == 3);
    btn_right = (which == 1 || which == 3);
    btn_down  = (which == 2);
    cyc(4);
    btn_fire = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
    cyc(LOCKOUT + 4);
    if (which == 1) exp_col = (exp_col + 1) % 5;
    if (which == 2) exp_row = (exp_row + 1) % 5;
  endtask

  // Short fire pulse; returns well before the PC would fire.
  task automatic fire_pulse();
    @(negedge clk);
    btn_fire = 1'b1;
    cyc(4);
    btn_fire = 1'b0;
    cyc(6);
  endtask

  task automatic read_cell(input logic b, input logic [2:0] r, input logic [2:0] c,
                           output logic [1:0] v);
    @(negedge clk);
    rd_board = b; rd_row = r; rd_col = c;
    @(negedge clk);
    v = rd_cell;
  endtask

  task automatic scan_board(input logic b);
    logic [1:0] v;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        read_cell(b, 3'(r), 3'(c), v);
        scan_buf[r*5+c] = v;
      end
  endtask

  function automatic int count_code(input logic [1:0] code);
    int n = 0;
    for (int i = 0; i < 25; i++) if (scan_buf[i] === code) n++;
    return n;
  endfunction

  task automatic find_boats();
    int k = 0;
    boat_r[0] = 0; boat_c[0] = 0; boat_r[1] = 0; boat_c[1] = 0;
    for (int i = 0; i < 25; i++)
      if (scan_buf[i] === 2'b01 && k < 2) begin
        boat_r[k] = i / 5;
        boat_c[k] = i % 5;
        k++;
      end
  endtask

  task automatic go_to(input int r, input int c);
    int guard = 0;
    while (exp_row != r && guard < 5) begin press(2); guard++; end
    guard = 0;
    while (exp_col != c && guard < 5) begin press(1); guard++; end
    check("goto_row", cur_row, exp_row);
    check("goto_col", cur_col, exp_col);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int k = 0;
    while (state_o !== s && k < budget) begin @(negedge clk); k++; end
    check("wait_state", state_o, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_cur_row"}, cur_row, 0);
    check({tag, "_cur_col"}, cur_col, 0);
    check({tag, "_cur_board"}, cur_board, 0);
    check({tag, "_hits_pl"}, hits_pl, 0);
    check({tag, "_hits_pc"}, hits_pc, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_winner"}, winner, 0);
    check({tag, "_rd_cell"}, rd_cell, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v;
    int diffs, chg;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 1};
    vecs[2] = '{2, 0, 1, 0, 1, 0, 0};
    vecs[3] = '{2, 0, 2, 0, 2, 0, 0};
    vecs[4] = '{2, 0, 3, 0, 3, 0, 0};
    vecs[5] = '{2, 0, 4, 0, 4, 0, 0};
    vecs[6] = '{2, 0, 0, 0, 0, 0, 1};
    vecs[7] = '{2, 0, 1, 0, 1, 0, 0};
    vecs[8] = '{1, 0, 1, 1, 1, 1, 0};
    vecs[9] = '{1, 0, 1, 2, 1, 2, 0};
    for (int i = 0; i < 25; i++) pl_model[i] = 2'b00;

    // Reset state
    cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(3);

    // Placement, nboat=2
    for (int i = 0; i < 10; i++) begin
      press(vecs[i].act);
      check("vec_state", state_o, vecs[i].e_state);
      check("vec_cur_row", cur_row, vecs[i].e_row);
      check("vec_cur_col", cur_col, vecs[i].e_col);
      check("vec_cur_board", cur_board, 0);
      read_cell(1'b0, 3'(vecs[i].c_row), 3'(vecs[i].c_col), v);
      check("vec_cell", v, vecs[i].e_cell);
      exp_row = vecs[i].e_row;
      exp_col = vecs[i].e_col;
    end
    read_cell(1'b0, 3'd5, 3'd0, v);
    check("oob_row_read", v, 0);
    read_cell(1'b1, 3'd0, 3'd7, v);
    check("oob_col_read", v, 0);

    // Second boat completes placement: 0 -> 1 -> 2
    @(negedge clk);
    btn_fire = 1'b1;
    wait_state(3'd1, 20);
    wait_state(3'd2, 500);
    btn_fire = 1'b0;
    cyc(LOCKOUT + 4);
    exp_row = 0; exp_col = 0;
    pl_model[0] = 2'b01;
    pl_model[7] = 2'b01;
    check("turn_cur_row", cur_row, 0);
    check("turn_cur_col", cur_col, 0);
    check("turn_cur_board", cur_board, 1);
    scan_board(1'b0);
    check("player_boats", count_code(2'b01), 2);
    read_cell(1'b0, 3'd1, 3'd2, v);
    check("player_cell_1_2", v, 1);
    scan_board(1'b1);
    check("enemy_boats", count_code(2'b01), 2);
    check("enemy_empty", count_code(2'b00), 23);
    find_boats();

    // Two right edges 10 cycles apart: only the first is accepted
    @(negedge clk);
    btn_right = 1'b1; cyc(3); btn_right = 1'b0; cyc(7);
    btn_right = 1'b1; cyc(3); btn_right = 1'b0;
    cyc(LOCKOUT + 10);
    check("lockout_cur_col", cur_col, 1);
    exp_col = 1;

    // Player hits first enemy boat, PC answers after its delay
    go_to(boat_r[0], boat_c[0]);
    fire_pulse();
    check("hit1_state", state_o, 3);
    check("hit1_hits_pl", hits_pl, 1);
    read_cell(1'b1, 3'(boat_r[0]), 3'(boat_c[0]), v);
    check("hit1_cell", v, 3);
    cyc(PC_DELAY + 50);
    check("pc_back_to_player", state_o, 2);
    scan_board(1'b0);
    diffs = 0; chg = -1;
    for (int i = 0; i < 25; i++)
      if (scan_buf[i] !== pl_model[i]) begin diffs++; chg = i; end
    check("pc_one_cell_changed", diffs, 1);
    if (chg >= 0) begin
      check("pc_mark_code", scan_buf[chg], {1'b1, pl_model[chg][0]});
      check("pc_hits", hits_pc, (pl_model[chg] == 2'b01) ? 1 : 0);
      pl_model[chg] = pl_model[chg] | 2'b10;
    end
    cyc(LOCKOUT);

    // Re-fire on the already-hit cell is ignored
    fire_pulse();
    check("refire_state", state_o, 2);
    check("refire_hits_pl", hits_pl, 1);
    read_cell(1'b1, 3'(boat_r[0]), 3'(boat_c[0]), v);
    check("refire_cell", v, 3);
    cyc(LOCKOUT);

    // Fire and right in the same cycle: move dropped
    press(3);
    check("fire_move_col", cur_col, exp_col);
    check("fire_move_row", cur_row, exp_row);
    check("fire_move_state", state_o, 2);

    // Second boat sinks: player wins
    go_to(boat_r[1], boat_c[1]);
    fire_pulse();
    check("win_state", state_o, 4);
    check("win_game_over", game_over, 1);
    check("win_winner", winner, 0);
    check("win_hits_pl", hits_pl, 2);
    cyc(LOCKOUT);

    // Restart with nboat=0 -> NB=1
    nboat = 4'd0;
    press(0);
    exp_row = 0; exp_col = 0;
    check("restart_state", state_o, 0);
    check("restart_hits_pl", hits_pl, 0);
    check("restart_hits_pc", hits_pc, 0);
    check("restart_game_over", game_over, 0);
    check("restart_cur_row", cur_row, 0);
    check("restart_cur_col", cur_col, 0);
    scan_board(1'b0);
    check("restart_player_clear", count_code(2'b00), 25);
    scan_board(1'b1);
    check("restart_enemy_clear", count_code(2'b00), 25);

    press(0);
    check("nb1_state", state_o, 2);
    scan_board(1'b1);
    check("nb1_enemy_boats", count_code(2'b01), 1);
    find_boats();
    go_to(boat_r[0], boat_c[0]);
    fire_pulse();
    check("nb1_game_over", game_over, 1);
    check("nb1_winner", winner, 0);
    cyc(LOCKOUT);

    // nboat=15 clamps to 8
    nboat = 4'd15;
    press(0);
    exp_row = 0; exp_col = 0;
    check("nb8_restart_state", state_o, 0);
    press(0); press(1); press(0); press(1); press(0); press(1); press(0);
    press(1); press(0); press(2); press(0); press(1); press(0); press(1);
    check("nb8_seven_placed_state", state_o, 0);
    press(0);
    check("nb8_state", state_o, 2);
    exp_row = 0; exp_col = 0;
    scan_board(1'b1);
    check("nb8_enemy_boats", count_code(2'b01), 8);
    fire_pulse();
    check("nb8_pc_turn", state_o, 3);

    // Asynchronous reset in PC_TURN, checked before any clock edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    scan_board(1'b0);
    check("async_player_clear", count_code(2'b00), 25);
    scan_board(1'b1);
    check("async_enemy_clear", count_code(2'b00), 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
